// File: rtl/gumnut_pkg.sv
// Shared definitions for the Gumnut interrupt controller.
//   REG_*    : register offsets from BASE_ADDR on the core port bus
//   int_id_t : interrupt source identifier (up to 8 sources)
package gumnut_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef logic [2:0] int_id_t;

endpackage

// File: rtl/gumnut_irq_sync.sv
// Per-line synchroniser for asynchronous interrupt inputs.
// Two flops resynchronise each line; a third stage delays the
// synchronised level so a rising edge can be detected.
//   clk, rst : clock, asynchronous active-high reset
//   irq      : raw interrupt lines (asynchronous)
//   level    : synchronised level
//   rise     : one-cycle pulse on a synchronised rising edge
module gumnut_irq_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;
  logic [WIDTH-1:0] stage3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= '0;
      stage2 <= '0;
      stage3 <= '0;
    end else begin
      stage1 <= irq;
      stage2 <= stage1;
      stage3 <= stage2;
    end
  end

  assign level = stage2;
  assign rise  = stage2 & ~stage3;

endmodule

// File: rtl/gumnut_int_ctrl.sv
// Port-mapped interrupt controller for the Gumnut core.
// Latches, masks and prioritises NUM_SRC interrupt lines (lowest index
// wins), drives int_req_o, records the in-service source on int_ack_i,
// and exposes PENDING/MASK/EDGE/STATUS registers at BASE_ADDR..+3.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   irq_i                 : raw interrupt lines
//   port_cyc_i/stb_i/we_i : port bus cycle, strobe, write enable
//   port_adr_i/dat_i      : port address, write data
//   port_dat_o/ack_o      : registered read data, one-cycle acknowledge
//   int_ack_i / int_req_o : interrupt handshake with the core
module gumnut_int_ctrl
  import gumnut_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               port_cyc_i,
  input  logic               port_stb_i,
  input  logic               port_we_i,
  input  logic [7:0]         port_adr_i,
  input  logic [7:0]         port_dat_i,
  output logic [7:0]         port_dat_o,
  output logic               port_ack_o,
  input  logic               int_ack_i,
  output logic               int_req_o
);

  logic [NUM_SRC-1:0] level;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pend_next;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] wdata;
  logic               isv;
  int_id_t            isid;
  int_id_t            win;
  logic [7:0]         offset;
  logic [1:0]         reg_sel;
  logic               hit;
  logic               wr_hit;
  logic               take;
  logic               eoi;
  logic [7:0]         rdata;

  gumnut_irq_sync #(.WIDTH(NUM_SRC)) u_sync (
    .clk   (clk_i),
    .rst   (rst_i),
    .irq   (irq_i),
    .level (level),
    .rise  (rise)
  );

  function automatic int_id_t prio(input logic [NUM_SRC-1:0] v);
    prio = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (v[i-1]) prio = int_id_t'(i - 1);
    end
  endfunction

  assign offset  = port_adr_i - BASE_ADDR;
  assign reg_sel = offset[1:0];
  // Suppressing on port_ack_o enforces the idle cycle between acks.
  assign hit     = port_cyc_i & port_stb_i & (offset[7:2] == 6'd0) & ~port_ack_o;
  assign wr_hit  = hit & port_we_i;
  assign wdata   = port_dat_i[NUM_SRC-1:0];
  assign eoi     = wr_hit && (reg_sel == REG_STAT);
  assign take    = int_ack_i & int_req_o;
  assign active  = pending & mask;
  // A late ack after the request was masked away still records the
  // lowest pending source (or 0), but clears nothing.
  assign win     = (active != '0) ? prio(active) : prio(pending);

  always_comb begin
    pend_next = pending;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!edge_mode[i]) begin
        pend_next[i] = level[i];
      end else begin
        if (wr_hit && (reg_sel == REG_PEND) && wdata[i]) pend_next[i] = 1'b0;
        if (take && (active != '0) && (win == int_id_t'(i))) pend_next[i] = 1'b0;
        // A fresh edge overrides any clear in the same cycle.
        if (rise[i]) pend_next[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_PEND: rdata[NUM_SRC-1:0] = pending;
      REG_MASK: rdata[NUM_SRC-1:0] = mask;
      REG_EDGE: rdata[NUM_SRC-1:0] = edge_mode;
      default:  rdata = {isv, 4'b0000, isid};
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      port_ack_o <= 1'b0;
      port_dat_o <= '0;
      int_req_o  <= 1'b0;
      pending    <= '0;
      mask       <= '0;
      edge_mode  <= '1;
      isv        <= 1'b0;
      isid       <= '0;
    end else begin
      port_ack_o <= hit;
      port_dat_o <= (hit && !port_we_i) ? rdata : 8'h00;
      pending    <= pend_next;
      if (wr_hit && (reg_sel == REG_MASK)) mask      <= wdata;
      if (wr_hit && (reg_sel == REG_EDGE)) edge_mode <= wdata;
      if (take) begin
        isv  <= 1'b1;
        isid <= win;
      end else if (eoi) begin
        isv  <= 1'b0;
      end
      int_req_o <= (active != '0) && !isv && !int_ack_i;
    end
  end

endmodule

// File: tb/tb_gumnut_int_ctrl.sv
module tb_gumnut_int_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq = 8'h00;
  logic       cyc = 1'b0;
  logic       stb = 1'b0;
  logic       we  = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] dat = 8'h00;
  logic [7:0] port_dat_o;
  logic       port_ack_o;
  logic       int_ack = 1'b0;
  logic       int_req_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  logic ackq[$];

  localparam logic [7:0] A_PEND = 8'hF0;
  localparam logic [7:0] A_MASK = 8'hF1;
  localparam logic [7:0] A_EDGE = 8'hF2;
  localparam logic [7:0] A_STAT = 8'hF3;

  gumnut_int_ctrl #(.NUM_SRC(8), .BASE_ADDR(8'hF0)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_i      (irq),
    .port_cyc_i (cyc),
    .port_stb_i (stb),
    .port_we_i  (we),
    .port_adr_i (adr),
    .port_dat_i (dat),
    .port_dat_o (port_dat_o),
    .port_ack_o (port_ack_o),
    .int_ack_i  (int_ack),
    .int_req_o  (int_req_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input string tag);
    logic got;
    got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      got = port_ack_o;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({tag, "_ack"}, {7'd0, got}, 8'h01);
    step();
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    exp_t e;
    logic got;
    sbq.push_back('{val: exp, tag: tag});
    got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      got = port_ack_o;
    end
    cyc = 1'b0; stb = 1'b0;
    e = sbq.pop_front();
    if (got) check(e.tag, port_dat_o, e.val);
    else     check({e.tag, "_timeout"}, 8'h00, 8'h01);
    step();
  endtask

  task automatic ack_int();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  initial begin
    logic a;
    exp_t e;

    // Reset state
    #1;
    check("rst_req", {7'd0, int_req_o}, 8'h00);
    check("rst_ack", {7'd0, port_ack_o}, 8'h00);
    check("rst_dat", port_dat_o, 8'h00);
    step(); step();
    rst = 1'b0;
    step();
    rd(A_PEND, 8'h00, "rst_pend");
    rd(A_MASK, 8'h00, "rst_mask");
    rd(A_EDGE, 8'hFF, "rst_edge");
    rd(A_STAT, 8'h00, "rst_stat");

    // Edge-triggered request on source 2
    wr(A_MASK, 8'h04, "e_mask");
    irq[2] = 1'b1;
    step();
    irq[2] = 1'b0;
    step(); step();
    check("e_req_early", {7'd0, int_req_o}, 8'h00);
    step();
    check("e_req", {7'd0, int_req_o}, 8'h01);
    ack_int();
    check("e_req_drop", {7'd0, int_req_o}, 8'h00);
    rd(A_STAT, 8'h82, "e_stat");
    rd(A_PEND, 8'h00, "e_pend");
    wr(A_STAT, 8'h00, "e_eoi");
    rd(A_STAT, 8'h02, "e_stat_eoi");

    // Priority between sources 5 and 1
    wr(A_MASK, 8'hFF, "p_mask");
    irq[5] = 1'b1; irq[1] = 1'b1;
    step(); step(); step(); step();
    check("p_req", {7'd0, int_req_o}, 8'h01);
    ack_int();
    rd(A_STAT, 8'h81, "p_stat1");
    rd(A_PEND, 8'h20, "p_pend1");
    wr(A_STAT, 8'h00, "p_eoi1");
    check("p_req_again", {7'd0, int_req_o}, 8'h01);
    ack_int();
    rd(A_STAT, 8'h85, "p_stat2");
    rd(A_PEND, 8'h00, "p_pend2");
    wr(A_STAT, 8'h00, "p_eoi2");
    irq[5] = 1'b0; irq[1] = 1'b0;
    step(); step(); step(); step();

    // Level-sensitive source 0
    wr(A_EDGE, 8'h00, "l_edge");
    wr(A_MASK, 8'h01, "l_mask");
    irq[0] = 1'b1;
    step(); step(); step(); step();
    check("l_req", {7'd0, int_req_o}, 8'h01);
    ack_int();
    check("l_req_drop", {7'd0, int_req_o}, 8'h00);
    rd(A_STAT, 8'h80, "l_stat");
    wr(A_STAT, 8'h00, "l_eoi");
    check("l_req_again", {7'd0, int_req_o}, 8'h01);
    rd(A_PEND, 8'h01, "l_pend_high");
    irq[0] = 1'b0;
    step();
    rd(A_PEND, 8'h01, "l_pend_hold");
    rd(A_PEND, 8'h00, "l_pend_clr");

    // Reset mid-run while a request is asserted
    irq[0] = 1'b1;
    step(); step(); step(); step();
    check("mr_req_pre", {7'd0, int_req_o}, 8'h01);
    rst = 1'b1;
    #1;
    check("mr_req", {7'd0, int_req_o}, 8'h00);
    check("mr_ack", {7'd0, port_ack_o}, 8'h00);
    check("mr_dat", port_dat_o, 8'h00);
    irq[0] = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    rd(A_PEND, 8'h00, "mr_pend");
    rd(A_MASK, 8'h00, "mr_mask");
    rd(A_EDGE, 8'hFF, "mr_edge");
    rd(A_STAT, 8'h00, "mr_stat");

    // Bus handshake with strobe held for three cycles
    wr(A_MASK, 8'h5A, "b_mask");
    ackq.push_back(1'b0); ackq.push_back(1'b1); ackq.push_back(1'b0); ackq.push_back(1'b1);
    sbq.push_back('{val: 8'h00, tag: "b_dat0"});
    sbq.push_back('{val: 8'h5A, tag: "b_dat1"});
    sbq.push_back('{val: 8'h00, tag: "b_dat2"});
    sbq.push_back('{val: 8'h5A, tag: "b_dat3"});
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_MASK;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      a = ackq.pop_front();
      check("b_ack", {7'd0, port_ack_o}, {7'd0, a});
      e = sbq.pop_front();
      check(e.tag, port_dat_o, e.val);
    end
    cyc = 1'b0; stb = 1'b0;
    step();

    // Out-of-range write
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'hEF; dat = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("oor_ack", {7'd0, port_ack_o}, 8'h00);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
    rd(A_MASK, 8'h5A, "oor_mask");

    // Edge and W1C on bit 3 in the same cycle
    irq[3] = 1'b1;
    step(); step();
    wr(A_PEND, 8'h08, "c_w1c");
    rd(A_PEND, 8'h08, "c_pend_kept");
    wr(A_PEND, 8'h08, "c_w1c2");
    rd(A_PEND, 8'h00, "c_pend_clr");
    irq[3] = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
